// File: rtl/msg_rotator_pkg.sv
// msg_pkg: shared states, sizes and blank code for the message rotator
package msg_pkg;
  localparam int MSG_LEN = 8;
  localparam int PTR_W = 3;
  localparam logic [2:0] CODE_BLANK = 3'b100;
  typedef enum logic [1:0] {EDIT, RUN, PAUSE} state_e;
endpackage

// File: rtl/msg_rotator_if.sv
// msg_rotator_if: switch/key inputs and per-digit code outputs of the rotator
interface msg_rotator_if;
  logic [2:0] SW;
  logic [1:0] KEY;
  logic [2:0] code3;
  logic [2:0] code2;
  logic [2:0] code1;
  logic [2:0] code0;
  logic       run_led;
  modport master (output SW, KEY, input code3, code2, code1, code0, run_led);
  modport slave (input SW, KEY, output code3, code2, code1, code0, run_led);
endinterface

// File: rtl/msg_rotator_key_edge.sv
// key_edge: two-flop synchroniser plus one-cycle pulse on each key press (falling edge)
module key_edge (
  input  logic clk,
  input  logic rstn,
  input  logic key_i,
  output logic press_o
);
  logic s1_q, s2_q, dly_q;
  always_ff @(posedge clk)
    if (!rstn) {s1_q, s2_q, dly_q} <= 3'b111;
    else {s1_q, s2_q, dly_q} <= {key_i, s1_q, s2_q};
  assign press_o = ~s2_q & dly_q;
endmodule

// File: rtl/msg_rotator.sv
// msg_rotator: eight-slot message editor with scrolling four-digit window
module msg_rotator
  import msg_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input logic CLOCK_50,
  input logic Resetn,
  msg_rotator_if.slave bus
);
  localparam int CW = $clog2(TICK_DIV);
  logic wr_press, run_press, we, wrap;
  state_e state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rot_ptr_q, rot_ptr_d, base;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] mem_q [MSG_LEN];
  logic [2:0] code_q [4];
  logic run_led_q;
  key_edge u_key_wr (.clk(CLOCK_50), .rstn(Resetn), .key_i(bus.KEY[0]), .press_o(wr_press));
  key_edge u_key_run (.clk(CLOCK_50), .rstn(Resetn), .key_i(bus.KEY[1]), .press_o(run_press));
  assign wrap = cnt_q == CW'(TICK_DIV - 1);
  // EDIT shows the four newest entries; RUN/PAUSE show the window starting at rot_ptr
  assign base = state_q == EDIT ? wr_ptr_q - PTR_W'(4) : rot_ptr_q;
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    rot_ptr_d = rot_ptr_q;
    cnt_d = cnt_q;
    we = 1'b0;
    case (state_q)
      EDIT:
        if (run_press) begin
          state_d = RUN;
          rot_ptr_d = '0;
          cnt_d = '0;
        end else if (wr_press) begin
          we = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      RUN: begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        rot_ptr_d = rot_ptr_q + PTR_W'(wrap);
        state_d = run_press ? PAUSE : RUN;
      end
      PAUSE: state_d = run_press ? RUN : wr_press ? EDIT : PAUSE;
      default: state_d = EDIT;
    endcase
  end
  always_ff @(posedge CLOCK_50)
    if (!Resetn) begin
      state_q <= EDIT;
      wr_ptr_q <= '0;
      rot_ptr_q <= '0;
      cnt_q <= '0;
      mem_q <= '{default: CODE_BLANK};
      code_q <= '{default: CODE_BLANK};
      run_led_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rot_ptr_q <= rot_ptr_d;
      cnt_q <= cnt_d;
      if (we) mem_q[wr_ptr_q] <= bus.SW;
      code_q[0] <= mem_q[base];
      code_q[1] <= mem_q[base + PTR_W'(1)];
      code_q[2] <= mem_q[base + PTR_W'(2)];
      code_q[3] <= mem_q[base + PTR_W'(3)];
      run_led_q <= state_q == RUN;
    end
  assign bus.code3 = code_q[0];
  assign bus.code2 = code_q[1];
  assign bus.code1 = code_q[2];
  assign bus.code0 = code_q[3];
  assign bus.run_led = run_led_q;
endmodule

// File: tb/tb_msg_rotator.sv
// tb_msg_rotator: directed checks of edit, scroll, pause and reset behaviour
module tb_msg_rotator;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [11:0] codes;
  logic [11:0] led;
  always #5 clk = ~clk;
  msg_rotator_if bus ();
  msg_rotator #(.TICK_DIV(4)) dut (.CLOCK_50(clk), .Resetn(rstn), .bus(bus));
  assign codes = {bus.code3, bus.code2, bus.code1, bus.code0};
  assign led = {11'b0, bus.run_led};
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %o expected %o", tag, obs, exp);
    end
  endtask
  task automatic tap(input int k, input int hold);
    @(negedge clk);
    bus.KEY[k] = 1'b0;
    repeat (hold) @(negedge clk);
    bus.KEY[k] = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.SW = 3'd0;
    bus.KEY = 2'b11;
    @(posedge clk);
    #1;
    chk("rst_codes", codes, 12'o4444);
    chk("rst_led", led, 12'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("edit_led", led, 12'd0);
    chk("edit_codes", codes, 12'o4444);
    @(negedge clk);
    bus.SW = 3'd0;
    bus.KEY[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("lat_n2", codes, 12'o4444);
    @(negedge clk);
    chk("lat_n3", codes, 12'o4440);
    bus.KEY[0] = 1'b1;
    repeat (3) @(negedge clk);
    bus.SW = 3'd1;
    tap(0, 1);
    chk("write1", codes, 12'o4401);
    bus.SW = 3'd2;
    tap(0, 1);
    chk("write2", codes, 12'o4012);
    bus.SW = 3'd3;
    tap(0, 100);
    chk("held_once", codes, 12'o0123);
    @(negedge clk);
    bus.KEY[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("run_codes", codes, 12'o0123);
    chk("run_led", led, 12'd1);
    bus.KEY[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("run_before_step", codes, 12'o0123);
    @(negedge clk);
    chk("run_step1", codes, 12'o1234);
    repeat (24) @(negedge clk);
    chk("run_rot7", codes, 12'o4012);
    repeat (4) @(negedge clk);
    chk("run_wrap", codes, 12'o0123);
    repeat (2) @(negedge clk);
    bus.KEY[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("pause_led", led, 12'd0);
    chk("pause_codes", codes, 12'o1234);
    bus.KEY[1] = 1'b1;
    repeat (50) @(negedge clk);
    chk("pause_frozen", codes, 12'o1234);
    chk("pause_led_held", led, 12'd0);
    @(negedge clk);
    bus.KEY[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("resume_led", led, 12'd1);
    chk("resume_n3", codes, 12'o1234);
    bus.KEY[1] = 1'b1;
    @(negedge clk);
    chk("resume_n4", codes, 12'o1234);
    @(negedge clk);
    chk("resume_step", codes, 12'o2344);
    tap(1, 1);
    chk("pause2_led", led, 12'd0);
    bus.SW = 3'd1;
    tap(0, 1);
    chk("pause_wr_edit", codes, 12'o0123);
    chk("pause_wr_led", led, 12'd0);
    @(negedge clk);
    bus.KEY = 2'b00;
    repeat (4) @(negedge clk);
    chk("both_led", led, 12'd1);
    chk("both_codes", codes, 12'o0123);
    bus.KEY = 2'b11;
    repeat (4) @(negedge clk);
    chk("both_nowrite", codes, 12'o1234);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("midrun_rst_codes", codes, 12'o4444);
    chk("midrun_rst_led", led, 12'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_edit", led, 12'd0);
    tap(1, 1);
    chk("post_rst_run", led, 12'd1);
    chk("mem_cleared", codes, 12'o4444);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/msg_rotator.md
Name: msg_rotator

Overview:
- Sequential front end for the DEC_7seg decoder bank on the DE board.
- Stores a user-entered message of eight 3-bit character codes and drives four 3-bit codes, one per HEX digit decoder.
- In EDIT, the codes show the most recent entries. In RUN, a four-character window scrolls through the message at a divided tick rate. PAUSE freezes the scroll.
- Character codes 0-3 are glyphs; codes 4-7 render blank. Code 3'b100 is the canonical blank.

Parameters:
- TICK_DIV, 50000000, clock cycles per scroll step (≥2); counter width is $clog2(TICK_DIV).
- MSG_LEN, 8, number of message slots; fixed at 8, so pointers are 3 bits and wrap naturally.

Ports:
- CLOCK_50  in  1  system clock.
- Resetn  in  1  reset; one clock, reset is synchronous and active-low.
- SW  in  3  character code to write.
- KEY  in  2  raw active-low pushbuttons. KEY[0] = write/edit, KEY[1] = run/pause.
- code3  out  3  character for HEX3 (leftmost).
- code2  out  3  character for HEX2.
- code1  out  3  character for HEX1.
- code0  out  3  character for HEX0 (rightmost).
- run_led  out  1  high while in RUN.

Behaviour:
- Reset (Resetn low at a rising edge of CLOCK_50):
  - state = EDIT; wr_ptr = 0; rot_ptr = 0; tick counter = 0.
  - All mem[0..7] = 3'b100.
  - code3..code0 = 3'b100; run_led = 0.
  - Key synchroniser flops = 1 (released).
  - Reset mid-RUN or mid-write aborts the operation; no partial write survives.
- Key path:
  - Each KEY bit passes through 2 flops, then a delay flop.
  - press = synced low AND delayed high. This gives one cycle per falling edge; a held key yields exactly one press.
  - KEY low first sampled at edge N → press committed at edge N+2 → codes/run_led updated at edge N+3.
- FSM, states EDIT, RUN, PAUSE:
  - EDIT, write press: mem[wr_ptr] <= SW; wr_ptr <= wr_ptr+1 (7 wraps to 0).
  - EDIT, run press: → RUN; rot_ptr <= 0; counter <= 0.
  - RUN:
    - Counter increments every cycle.
    - At TICK_DIV-1 the counter wraps to 0 and rot_ptr <= rot_ptr+1 mod 8.
    - Run press → PAUSE.
    - Write press is ignored.
  - PAUSE:
    - Counter and rot_ptr hold.
    - Run press → RUN, resuming from the held counter value.
    - Write press → EDIT with no write; wr_ptr is unchanged.
  - Simultaneous write and run press in the same cycle: the run press wins and the write is discarded.
  - A run press on the same cycle as a counter wrap: the transition to PAUSE and the rot_ptr increment both take effect.
- Outputs (registered, all indices mod 8):
  - EDIT: code0 = mem[wr_ptr-1], code1 = mem[wr_ptr-2], code2 = mem[wr_ptr-3], code3 = mem[wr_ptr-4]. The newest character appears at the right and scrolls in leftward.
  - RUN/PAUSE: code3 = mem[rot_ptr], code2 = mem[rot_ptr+1], code1 = mem[rot_ptr+2], code0 = mem[rot_ptr+3].
  - run_led = (state == RUN), registered.
- Entering more than 8 characters overwrites the oldest slots circularly; no full flag.

Decomposition:
- Shared package msg_pkg contains:
  - state enum {EDIT, RUN, PAUSE};
  - constant CODE_BLANK = 3'b100;
  - MSG_LEN = 8 and PTR_W = 3.
- One sub-module, key_edge: 2-flop synchroniser plus falling-edge one-shot, with a synchronous active-low reset to the released state. It is instantiated twice.

Test Plan:
1. Reset → all codes 3'b100 and run_led = 0 at the first edge after Resetn falls; state holds EDIT after Resetn rises.
2. EDIT: write SW = 0,1,2,3 with four presses → code3..code0 = 0,1,2,3. A held KEY[0] for 100 cycles writes only once.
3. Entry latency: press KEY[0] first sampled at edge N → code0 changes at edge N+3, not N+2.
4. RUN scroll, TICK_DIV = 4, mem = 0,1,2,3 followed by blanks:
   - After the run press: codes 0,1,2,3, run_led = 1.
   - After 4 cycles: 1,2,3,4.
   - After 32 cycles, rot_ptr has wrapped: codes back to 0,1,2,3.
5. PAUSE/resume, TICK_DIV = 4: pause with the counter at 2 → codes frozen for 50 cycles; resume → the next step occurs after exactly 2 cycles. A write press in PAUSE returns to EDIT, mem unchanged.
6. Conflicts: simultaneous KEY[0] and KEY[1] in EDIT → RUN entered, no mem write. Resetn low mid-RUN → all codes blank next edge, mem cleared, state EDIT.
